// File: rtl/bus_arbiter_if.sv
// rtl/bus_arbiter_if.sv - two-master request bus plus system-bridge side of the arbiter.
interface bus_arbiter_if;
    logic        req0;
    logic        we0;
    logic [31:0] addr0;
    logic [31:0] wdata0;
    logic        req1;
    logic        we1;
    logic [31:0] addr1;
    logic [31:0] wdata1;
    logic        ack0;
    logic        ack1;
    logic        err0;
    logic        err1;
    logic [31:0] rdata;
    logic [31:0] busAddr;
    logic [31:0] busWdata;
    logic        busWe;
    logic [31:0] busRdata;
    logic        owner;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  busRdata,
        output ack0, ack1, err0, err1, rdata,
        output busAddr, busWdata, busWe, owner
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output busRdata,
        input  ack0, ack1, err0, err1, rdata,
        input  busAddr, busWdata, busWe, owner
    );
endinterface

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin two-master arbiter with address decode, IDLE/ACCESS/RESP per transaction.
module bus_arbiter (
    input  logic         clk,
    input  logic         reset,
    bus_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state, stateNext;
    logic        owner, ownerNext;
    logic        lastGrant, lastGrantNext;
    logic        grantWinner;
    logic        errReg;
    logic [31:0] rdataReg;
    logic [31:0] selAddr;
    logic [31:0] selWdata;
    logic        selWe;
    logic        addrLegal;
    logic        inAccess;

    // Memory window plus the small timer block; everything else is rejected.
    function automatic logic isLegal(input logic [31:0] a);
        return (a <= 32'h0000_2FFF) || ((a >= 32'h0000_7F00) && (a <= 32'h0000_7F1F));
    endfunction

    assign selAddr   = owner ? bus.addr1  : bus.addr0;
    assign selWdata  = owner ? bus.wdata1 : bus.wdata0;
    assign selWe     = owner ? bus.we1    : bus.we0;
    assign addrLegal = isLegal(selAddr);
    assign inAccess  = (state == ACCESS);

    // lastGrant resets to 1 so master 0 wins the first contention.
    assign grantWinner = (bus.req0 && bus.req1) ? ~lastGrant : bus.req1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            owner     <= 1'b0;
            lastGrant <= 1'b1;
            rdataReg  <= 32'h0;
            errReg    <= 1'b0;
        end else begin
            state     <= stateNext;
            owner     <= ownerNext;
            lastGrant <= lastGrantNext;
            if (inAccess) begin
                rdataReg <= addrLegal ? bus.busRdata : 32'h0;
                errReg   <= ~addrLegal;
            end
        end
    end

    always_comb begin
        stateNext     = state;
        ownerNext     = owner;
        lastGrantNext = lastGrant;
        case (state)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    stateNext     = ACCESS;
                    ownerNext     = grantWinner;
                    lastGrantNext = grantWinner;
                end
            end
            ACCESS:  stateNext = RESP;
            RESP:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    assign bus.busAddr  = inAccess ? selAddr  : 32'h0;
    assign bus.busWdata = inAccess ? selWdata : 32'h0;
    assign bus.busWe    = inAccess & selWe & addrLegal;

    assign bus.ack0  = (state == RESP) && !owner;
    assign bus.ack1  = (state == RESP) &&  owner;
    assign bus.err0  = bus.ack0 && errReg;
    assign bus.err1  = bus.ack1 && errReg;
    assign bus.rdata = rdataReg;
    assign bus.owner = owner;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - scoreboard bench for bus_arbiter with directed transactions.
module tb_bus_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cycleCnt = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        int          master;
        logic        err;
        logic [31:0] rdata;
        int          cycle;
    } exp_t;

    exp_t expQ[$];
    exp_t monE;

    bus_arbiter_if busIf();

    bus_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (busIf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Bridge model: one fixed word at 0x10, otherwise a tag plus the low address half.
    assign busIf.busRdata = (busIf.busAddr == 32'h10) ? 32'h1234_5678
                                                      : {16'hBEEF, busIf.busAddr[15:0]};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset && (busIf.ack0 || busIf.ack1)) begin
            check("ack_exclusive", {31'b0, busIf.ack0 & busIf.ack1}, 32'h0);
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack actual ack0=%0b ack1=%0b required none", busIf.ack0, busIf.ack1);
            end else begin
                monE = expQ.pop_front();
                check("ack_master", busIf.ack1 ? 32'd1 : 32'd0, monE.master);
                check("ack_err", {31'b0, busIf.ack1 ? busIf.err1 : busIf.err0}, {31'b0, monE.err});
                check("other_err", {31'b0, busIf.ack1 ? busIf.err0 : busIf.err1}, 32'h0);
                check("ack_rdata", busIf.rdata, monE.rdata);
                check("ack_cycle", cycleCnt, monE.cycle);
            end
        end
    end

    task automatic setMaster(input int m, input logic req, input logic we,
                             input logic [31:0] addr, input logic [31:0] wdata);
        if (m == 0) begin
            busIf.req0 = req; busIf.we0 = we; busIf.addr0 = addr; busIf.wdata0 = wdata;
        end else begin
            busIf.req1 = req; busIf.we1 = we; busIf.addr1 = addr; busIf.wdata1 = wdata;
        end
    endtask

    // Entered #1 after a rising edge with the arbiter in IDLE.
    task automatic runTxn(input int m, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic expWe, input logic expErr,
                          input logic [31:0] expRdata, input logic dropReq);
        exp_t e;
        check("idle_busWe", {31'b0, busIf.busWe}, 32'h0);
        check("idle_busAddr", busIf.busAddr, 32'h0);
        setMaster(m, 1'b1, we, addr, wdata);
        e.master = m; e.err = expErr; e.rdata = expRdata; e.cycle = cycleCnt + 2;
        expQ.push_back(e);
        @(posedge clk); #1;
        check("access_busAddr", busIf.busAddr, addr);
        check("access_busWdata", busIf.busWdata, wdata);
        check("access_busWe", {31'b0, busIf.busWe}, {31'b0, expWe});
        check("access_owner", {31'b0, busIf.owner}, m);
        if (dropReq) begin
            if (m == 0) busIf.req0 = 1'b0; else busIf.req1 = 1'b0;
        end
        @(posedge clk); #1;
        check("resp_busWe", {31'b0, busIf.busWe}, 32'h0);
        check("resp_busWdata", busIf.busWdata, 32'h0);
        setMaster(m, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;
        check("ack_latency", expQ.size(), 32'h0);
    endtask

    task automatic holdReset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e;
        int   c0;
        setMaster(0, 1'b0, 1'b0, 32'h0, 32'h0);
        setMaster(1, 1'b0, 1'b0, 32'h0, 32'h0);
        holdReset();
        check("rst_busWe", {31'b0, busIf.busWe}, 32'h0);
        check("rst_busAddr", busIf.busAddr, 32'h0);
        check("rst_acks", {28'b0, busIf.ack0, busIf.ack1, busIf.err0, busIf.err1}, 32'h0);
        check("rst_rdata", busIf.rdata, 32'h0);
        check("rst_owner", {31'b0, busIf.owner}, 32'h0);
        reset = 1'b1;

        runTxn(0, 1'b0, 32'h0000_0010, 32'h0, 1'b0, 1'b0, 32'h1234_5678, 1'b0);
        runTxn(1, 1'b1, 32'h0000_5000, 32'h55AA_55AA, 1'b0, 1'b1, 32'h0, 1'b0);
        runTxn(0, 1'b1, 32'h0000_2FFC, 32'h1111_1111, 1'b1, 1'b0, 32'hBEEF_2FFC, 1'b0);
        runTxn(1, 1'b1, 32'h0000_7F00, 32'h2222_2222, 1'b1, 1'b0, 32'hBEEF_7F00, 1'b0);
        runTxn(0, 1'b1, 32'h0000_7F1C, 32'h3333_3333, 1'b1, 1'b0, 32'hBEEF_7F1C, 1'b0);
        runTxn(1, 1'b1, 32'h0000_3000, 32'h4444_4444, 1'b0, 1'b1, 32'h0, 1'b0);
        runTxn(0, 1'b1, 32'h0000_7F20, 32'h5555_5555, 1'b0, 1'b1, 32'h0, 1'b0);
        runTxn(1, 1'b0, 32'h0000_7F1F, 32'h0, 1'b0, 1'b0, 32'hBEEF_7F1F, 1'b0);
        runTxn(0, 1'b0, 32'h0000_0200, 32'h0, 1'b0, 1'b0, 32'hBEEF_0200, 1'b1);

        // Both masters requesting continuously from reset release.
        holdReset();
        setMaster(0, 1'b1, 1'b0, 32'h0000_0100, 32'h0);
        setMaster(1, 1'b1, 1'b0, 32'h0000_0200, 32'h0);
        c0 = cycleCnt;
        for (int i = 0; i < 4; i++) begin
            e.master = i % 2;
            e.err    = 1'b0;
            e.rdata  = (i % 2 == 0) ? 32'hBEEF_0100 : 32'hBEEF_0200;
            e.cycle  = c0 + 2 + 3 * i;
            expQ.push_back(e);
        end
        reset = 1'b1;
        repeat (11) @(posedge clk);
        #1;
        setMaster(0, 1'b0, 1'b0, 32'h0, 32'h0);
        setMaster(1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;
        check("contention_drained", expQ.size(), 32'h0);

        // Reset lands in the middle of a write access.
        setMaster(0, 1'b1, 1'b1, 32'h0000_0100, 32'hCAFE_0001);
        @(posedge clk); #1;
        check("pre_rst_busWe", {31'b0, busIf.busWe}, 32'h1);
        #2 reset = 1'b0;
        #1;
        check("async_busWe", {31'b0, busIf.busWe}, 32'h0);
        check("async_busAddr", busIf.busAddr, 32'h0);
        check("async_busWdata", busIf.busWdata, 32'h0);
        check("async_rdata", busIf.rdata, 32'h0);
        check("async_owner", {31'b0, busIf.owner}, 32'h0);
        setMaster(0, 1'b0, 1'b0, 32'h0, 32'h0);
        setMaster(1, 1'b1, 1'b0, 32'h0000_0300, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        runTxn(1, 1'b0, 32'h0000_0300, 32'h0, 1'b0, 1'b0, 32'hBEEF_0300, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("final_drained", expQ.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
